// File: rtl/serial_transmitter.sv
// Parallel-to-serial link transmitter: programmable lead-in delay, selectable bit order.
// Optional even-parity bit after the payload when SERIAL_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line low, waiting for start
// WAIT   | lead-in delay, D cycles of line low
// SHIFT  | 8 payload bits, bit_valid high
// PARITY | even-parity bit (SERIAL_TX_PARITY_EN only)
// DONE   | one-cycle done pulse, then back to IDLE
module serial_transmitter (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] din,
  input  logic [1:0] F,
  input  logic [3:0] m,
  output logic       data,
  output logic       bit_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0] r_state;
  logic [7:0] r_shift;
  logic       r_lsb;
  logic [3:0] r_dly_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_data;
`ifdef SERIAL_TX_PARITY_EN
  logic       r_parity;
`endif

  logic [3:0] w_dly;
  logic [7:0] w_src;
  logic       w_lsb_sel;
  logic       w_first;
  logic [7:0] w_shifted;

  assign w_dly = F[1] ? m : 4'd4;

  // In IDLE the first bit comes straight from the inputs so D=0 needs no extra cycle.
  assign w_src     = (r_state == S_IDLE) ? din  : r_shift;
  assign w_lsb_sel = (r_state == S_IDLE) ? F[0] : r_lsb;
  assign w_first   = w_lsb_sel ? w_src[0] : w_src[7];
  assign w_shifted = w_lsb_sel ? {1'b0, w_src[7:1]} : {w_src[6:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'd0;
      r_lsb     <= 1'b0;
      r_dly_cnt <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_data    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (en) begin
      case (r_state)
        S_IDLE: begin
          r_data <= 1'b0;
          if (start) begin
            r_lsb <= F[0];
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= ^din;
`endif
            if (w_dly == 4'd0) begin
              r_state   <= S_SHIFT;
              r_data    <= w_first;
              r_shift   <= w_shifted;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state   <= S_WAIT;
              r_shift   <= din;
              r_dly_cnt <= w_dly;
            end
          end
        end
        S_WAIT: begin
          if (r_dly_cnt == 4'd1) begin
            r_state   <= S_SHIFT;
            r_data    <= w_first;
            r_shift   <= w_shifted;
            r_bit_cnt <= 3'd0;
            r_dly_cnt <= 4'd0;
          end else begin
            r_dly_cnt <= r_dly_cnt - 4'd1;
          end
        end
        S_SHIFT: begin
          if (r_bit_cnt == 3'd7) begin
            r_bit_cnt <= 3'd0;
`ifdef SERIAL_TX_PARITY_EN
            r_state <= S_PARITY;
            r_data  <= r_parity;
`else
            r_state <= S_DONE;
            r_data  <= 1'b0;
`endif
          end else begin
            r_data    <= w_first;
            r_shift   <= w_shifted;
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY: begin
          r_state <= S_DONE;
          r_data  <= 1'b0;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
          r_data  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_data  <= 1'b0;
        end
      endcase
    end
  end

  assign data = r_data;
`ifdef SERIAL_TX_PARITY_EN
  assign bit_valid = (r_state == S_SHIFT) || (r_state == S_PARITY);
`else
  assign bit_valid = (r_state == S_SHIFT);
`endif
  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter; output vector per cycle is {data, bit_valid, busy, done}.
module tb_serial_transmitter;

  logic       clk = 1'b0;
  logic       reset, en, start;
  logic [7:0] din;
  logic [1:0] F;
  logic [3:0] m;
  logic       data, bit_valid, busy, done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR_CYC = 1;
`else
  localparam int PAR_CYC = 0;
`endif

  always #5 clk = ~clk;

  serial_transmitter dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .din(din), .F(F), .m(m),
    .data(data), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // seq[7] is the first bit expected on the line.
  task automatic xfer(input string tag, input logic [7:0] d, input logic [1:0] f,
                      input logic [3:0] mm, input logic [7:0] seq, input int dly,
                      input logic par, input bit hold);
    int total;
    logic [3:0] e;
    total = dly + 9 + PAR_CYC;
    din = d; F = f; m = mm; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    din = ~d; F = ~f; m = ~mm;
    for (int k = 1; k <= total; k++) begin
      if (k <= dly) e = 4'b0010;
      else if (k <= dly + 8) e = {seq[7 - (k - dly - 1)], 3'b110};
      else if (PAR_CYC == 1 && k == dly + 9) e = {par, 3'b110};
      else e = 4'b0011;
      check_val($sformatf("%s_c%0d", tag, k), {28'd0, data, bit_valid, busy, done}, {28'd0, e});
      if (k == total) start = 1'b0;
      tick();
    end
    check_val({tag, "_idle"}, {28'd0, data, bit_valid, busy, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; din = 8'd0; F = 2'd0; m = 4'd0;
    tick(); tick();
    check_val("reset", {28'd0, data, bit_valid, busy, done}, 32'd0);
    reset = 1'b0;
    tick();

    xfer("a5_msb", 8'hA5, 2'b00, 4'd9, 8'b10100101, 4, 1'b0, 1'b0);
    xfer("a5_lsb_m2", 8'hA5, 2'b11, 4'd2, 8'b10100101, 2, 1'b0, 1'b0);
    xfer("81_d0_hold", 8'h81, 2'b10, 4'd0, 8'b10000001, 0, 1'b0, 1'b1);
    xfer("12_lsb_m1", 8'h12, 2'b11, 4'd1, 8'b01001000, 1, 1'b0, 1'b0);
    xfer("12_msb_m5", 8'h12, 2'b10, 4'd5, 8'b00010010, 5, 1'b0, 1'b0);

    // en dropped for 3 cycles while the 4th data bit is on the line
    din = 8'hF0; F = 2'b00; m = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      check_val($sformatf("stall_pre%0d", k), {28'd0, data, bit_valid, busy, done},
                (k <= 4) ? 32'h2 : 32'hE);
      tick();
    end
    check_val("stall_bit4", {28'd0, data, bit_valid, busy, done}, 32'hE);
    en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val($sformatf("stall_hold%0d", k), {28'd0, data, bit_valid, busy, done}, 32'hE);
    end
    en = 1'b1;
    for (int k = 5; k <= 8; k++) begin
      tick();
      check_val($sformatf("stall_bit%0d", k), {28'd0, data, bit_valid, busy, done}, 32'h6);
    end
    tick();
    if (PAR_CYC == 1) begin
      check_val("stall_par", {28'd0, data, bit_valid, busy, done}, 32'h6);
      tick();
    end
    check_val("stall_done", {28'd0, data, bit_valid, busy, done}, 32'h3);
    tick();
    check_val("stall_idle", {28'd0, data, bit_valid, busy, done}, 32'h0);

    // reset in the middle of SHIFT
    din = 8'hA5; F = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check_val("rst_in_shift", {31'd0, bit_valid}, 32'd1);
    reset = 1'b1;
    tick();
    check_val("rst_abort", {28'd0, data, bit_valid, busy, done}, 32'h0);
    reset = 1'b0;
    tick();
    check_val("rst_no_done", {28'd0, data, bit_valid, busy, done}, 32'h0);
    xfer("after_rst", 8'h12, 2'b01, 4'd0, 8'b01001000, 4, 1'b0, 1'b0);

    xfer("par_07", 8'h07, 2'b10, 4'd1, 8'b00000111, 1, 1'b1, 1'b0);
    xfer("par_03", 8'h03, 2'b11, 4'd0, 8'b11000000, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
